// File: rtl/fp_pkg.sv
// Shared definitions for the floating-point add/sub datapath: flag bit
// positions, operand classes and the canonical quiet-NaN pattern.
package fp_pkg;

    localparam int FLG_INVALID   = 4;
    localparam int FLG_OVERFLOW  = 3;
    localparam int FLG_UNDERFLOW = 2;
    localparam int FLG_INEXACT   = 1;
    localparam int FLG_ZERO      = 0;
    localparam int FLG_W         = 5;

    typedef enum logic [1:0] {FP_ZERO, FP_NORM, FP_INF, FP_NAN} fp_class_e;

    // {0, all-ones exponent, 1 followed by zeros}, right-aligned in 64 bits
    function automatic logic [63:0] fp_qnan(input int exp_w, input int man_w);
        logic [63:0] q;
        q = ((64'd1 << exp_w) - 64'd1) << man_w;
        q = q | (64'd1 << (man_w - 1));
        return q;
    endfunction

endpackage

// File: rtl/fp_lzc.sv
// Leading-zero counter; an all-zero input reports WIDTH.
module fp_lzc #(
    parameter int WIDTH = 28,
    parameter int CW    = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] d,
    output logic [CW-1:0]    cnt
);

    // Scanning upward lets the highest set bit win.
    always_comb begin
        cnt = CW'(WIDTH);
        for (int i = 0; i < WIDTH; i++) begin
            if (d[i]) cnt = CW'(WIDTH - 1 - i);
        end
    end

endmodule

// File: rtl/fp_addsub_pipe.sv
// Three-stage floating-point adder/subtractor (align, add, normalise+round).
// Define FP_ADDSUB_RNE_EN for round-to-nearest-even; otherwise rounds toward zero.
module fp_addsub_pipe
    import fp_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int TAG_W = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [EXP_W+MAN_W:0]     in_a,
    input  logic [EXP_W+MAN_W:0]     in_b,
    input  logic                     in_sub,
    input  logic [TAG_W-1:0]         in_tag,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [EXP_W+MAN_W:0]     out_y,
    output logic [TAG_W-1:0]         out_tag,
    output logic [FLG_W-1:0]         out_flags
);

    localparam int W   = 1 + EXP_W + MAN_W;
    localparam int FW  = MAN_W + 4;
    localparam int AW  = MAN_W + 5;
    localparam int CW  = $clog2(AW + 1);
    localparam int EW2 = EXP_W + 2;
    localparam logic [W-1:0]            QNAN   = W'(fp_qnan(EXP_W, MAN_W));
    localparam logic signed [EW2-1:0]   E_MAX  = {2'b00, {EXP_W{1'b1}}};
    localparam logic signed [EW2-1:0]   E_ZERO = '0;
    localparam logic signed [EW2-1:0]   E_ONE  = {{(EW2-1){1'b0}}, 1'b1};

    function automatic fp_class_e fp_class(input logic [EXP_W-1:0] e, input logic [MAN_W-1:0] m);
        fp_class_e c;
        if (e == '0)          c = FP_ZERO;
        else if (&e)          c = (m == '0) ? FP_INF : FP_NAN;
        else                  c = FP_NORM;
        return c;
    endfunction

    // Valid/ready: data moves across a boundary on every edge where valid and
    // ready are both high; a stage loads when it is empty or draining this
    // cycle, so out_y/out_tag/out_flags hold while out_valid && !out_ready.
    logic s1_valid, s2_valid, s3_valid;
    logic s1_ready, s2_ready, s3_ready;

    assign s3_ready  = !s3_valid || out_ready;
    assign s2_ready  = !s2_valid || s3_ready;
    assign s1_ready  = !s1_valid || s2_ready;
    assign in_ready  = s1_ready;
    assign out_valid = s3_valid;

    // ---------------- S1: decode, specials, align ----------------
    logic               a_s, b_s, x_s, a_big;
    logic [EXP_W-1:0]   a_e, b_e, x_e, y_e, e_diff;
    logic [MAN_W-1:0]   a_m, b_m, x_m, y_m;
    fp_class_e          a_c, b_c;
    logic [FW-1:0]      y_ext, y_shr, y_lost;
    logic               spec_d;
    logic [W-1:0]       spec_y_d;
    logic [FLG_W-1:0]   spec_f_d;

    always_comb begin
        a_s = in_a[W-1];
        a_e = in_a[W-2:MAN_W];
        a_m = in_a[MAN_W-1:0];
        b_s = in_b[W-1] ^ in_sub;
        b_e = in_b[W-2:MAN_W];
        b_m = in_b[MAN_W-1:0];
        a_c = fp_class(a_e, a_m);
        b_c = fp_class(b_e, b_m);

        a_big  = {a_e, a_m} >= {b_e, b_m};
        x_s    = a_big ? a_s : b_s;
        x_e    = a_big ? a_e : b_e;
        x_m    = a_big ? a_m : b_m;
        y_e    = a_big ? b_e : a_e;
        y_m    = a_big ? b_m : a_m;
        e_diff = x_e - y_e;

        // Shifts past the field width leave zero, so every bit lands in sticky.
        y_ext  = {1'b1, y_m, 3'b000};
        y_shr  = y_ext >> e_diff;
        y_lost = y_ext & ~({FW{1'b1}} << e_diff);

        spec_d   = 1'b1;
        spec_y_d = '0;
        spec_f_d = '0;
        if (a_c == FP_NAN || b_c == FP_NAN || (a_c == FP_INF && b_c == FP_INF && a_s != b_s)) begin
            spec_y_d              = QNAN;
            spec_f_d[FLG_INVALID] = 1'b1;
        end else if (a_c == FP_INF) begin
            spec_y_d = in_a;
        end else if (b_c == FP_INF) begin
            spec_y_d = {b_s, b_e, b_m};
        end else if (a_c == FP_ZERO && b_c == FP_ZERO) begin
            spec_y_d           = {a_s & b_s, {(W-1){1'b0}}};
            spec_f_d[FLG_ZERO] = 1'b1;
        end else if (a_c == FP_ZERO) begin
            spec_y_d = {b_s, b_e, b_m};
        end else if (b_c == FP_ZERO) begin
            spec_y_d = in_a;
        end else begin
            spec_d = 1'b0;
        end
    end

    logic               s1_spec, s1_sign, s1_eff_sub;
    logic [W-1:0]       s1_spec_y;
    logic [FLG_W-1:0]   s1_spec_f;
    logic [EXP_W-1:0]   s1_exp;
    logic [FW-1:0]      s1_x, s1_y;
    logic [TAG_W-1:0]   s1_tag;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid   <= 1'b0;
            s1_tag     <= '0;
            s1_spec    <= 1'b0;
            s1_spec_y  <= '0;
            s1_spec_f  <= '0;
            s1_sign    <= 1'b0;
            s1_eff_sub <= 1'b0;
            s1_exp     <= '0;
            s1_x       <= '0;
            s1_y       <= '0;
        end else if (s1_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_tag     <= in_tag;
                s1_spec    <= spec_d;
                s1_spec_y  <= spec_y_d;
                s1_spec_f  <= spec_f_d;
                s1_sign    <= x_s;
                s1_eff_sub <= a_s ^ b_s;
                s1_exp     <= x_e;
                s1_x       <= {1'b1, x_m, 3'b000};
                s1_y       <= {y_shr[FW-1:1], y_shr[0] | (|y_lost)};
            end
        end
    end

    // ---------------- S2: significand add/subtract ----------------
    logic [AW-1:0] sum_d;

    assign sum_d = s1_eff_sub ? ({1'b0, s1_x} - {1'b0, s1_y})
                              : ({1'b0, s1_x} + {1'b0, s1_y});

    logic               s2_spec, s2_sign;
    logic [W-1:0]       s2_spec_y;
    logic [FLG_W-1:0]   s2_spec_f;
    logic [EXP_W-1:0]   s2_exp;
    logic [AW-1:0]      s2_sum;
    logic [TAG_W-1:0]   s2_tag;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s2_valid  <= 1'b0;
            s2_tag    <= '0;
            s2_spec   <= 1'b0;
            s2_spec_y <= '0;
            s2_spec_f <= '0;
            s2_sign   <= 1'b0;
            s2_exp    <= '0;
            s2_sum    <= '0;
        end else if (s2_ready) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_tag    <= s1_tag;
                s2_spec   <= s1_spec;
                s2_spec_y <= s1_spec_y;
                s2_spec_f <= s1_spec_f;
                s2_sign   <= s1_sign;
                s2_exp    <= s1_exp;
                s2_sum    <= sum_d;
            end
        end
    end

    // ---------------- S3: normalise, round, exceptions ----------------
    logic [CW-1:0]          lz, shl;
    logic                   carry, inexact, rnd_c;
    logic [FW-1:0]          norm;
    logic [MAN_W-1:0]       man;
    logic signed [EW2-1:0]  e_norm, e_fin;
    logic [W-1:0]           res_y;
    logic [FLG_W-1:0]       res_f;
`ifdef FP_ADDSUB_RNE_EN
    logic                   round_up;
`endif

    fp_lzc #(.WIDTH(AW), .CW(CW)) u_lzc (
        .d   (s2_sum),
        .cnt (lz)
    );

    always_comb begin
        carry  = s2_sum[AW-1];
        shl    = carry ? '0 : lz - CW'(1);
        norm   = carry ? {s2_sum[AW-1:2], s2_sum[1] | s2_sum[0]} : FW'(s2_sum << shl);
        e_norm = $signed({2'b00, s2_exp}) - $signed({{(EW2-CW){1'b0}}, shl});
        if (carry) e_norm = e_norm + E_ONE;
        inexact = |norm[2:0];
`ifdef FP_ADDSUB_RNE_EN
        // Ties go up only when that makes the mantissa even.
        round_up     = norm[2] & (norm[1] | norm[0] | norm[3]);
        {rnd_c, man} = {1'b0, norm[FW-2:3]} + {{MAN_W{1'b0}}, round_up};
`else
        {rnd_c, man} = {1'b0, norm[FW-2:3]};
`endif
        e_fin = rnd_c ? e_norm + E_ONE : e_norm;

        res_y = '0;
        res_f = '0;
        if (s2_spec) begin
            res_y = s2_spec_y;
            res_f = s2_spec_f;
        end else if (!norm[FW-1]) begin
            // exact cancellation always yields +0
            res_f[FLG_ZERO] = 1'b1;
        end else if (e_fin >= E_MAX) begin
            res_y                = {s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            res_f[FLG_OVERFLOW]  = 1'b1;
            res_f[FLG_INEXACT]   = 1'b1;
        end else if (e_fin <= E_ZERO) begin
            res_y                = {s2_sign, {(W-1){1'b0}}};
            res_f[FLG_UNDERFLOW] = 1'b1;
            res_f[FLG_INEXACT]   = 1'b1;
            res_f[FLG_ZERO]      = 1'b1;
        end else begin
            res_y              = {s2_sign, e_fin[EXP_W-1:0], man};
            res_f[FLG_INEXACT] = inexact;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s3_valid  <= 1'b0;
            out_tag   <= '0;
            out_y     <= '0;
            out_flags <= '0;
        end else if (s3_ready) begin
            s3_valid <= s2_valid;
            if (s2_valid) begin
                out_tag   <= s2_tag;
                out_y     <= res_y;
                out_flags <= res_f;
            end
        end
    end

endmodule
